// File: rtl/log_op_pkg.sv
// Shared constants for the logical-operator scheduler: op codes and FSM state encodings.
package log_op_pkg;

    localparam logic [2:0] OP_OR_AB      = 3'd0;
    localparam logic [2:0] OP_AND_AC     = 3'd1;
    localparam logic [2:0] OP_NOT_B      = 3'd2;
    localparam logic [2:0] OP_NOTB_OR_C  = 3'd3;
    localparam logic [2:0] OP_A_ANDNOT_C = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StExec = ST_EXEC,
        StHold = ST_HOLD
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_A_ANDNOT_C;
    endfunction

endpackage

// File: rtl/log_op_eval.sv
// Combinational evaluator: reduces each operand to "nonzero" and applies the selected op.
module log_op_eval
    import log_op_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [2:0]   op_i,
    output logic         bit_o,
    output logic         err_o
);

    logic any_a;
    logic any_b;
    logic any_c;

    assign any_a = |a_i;
    assign any_b = |b_i;
    assign any_c = |c_i;

    always_comb begin
        bit_o = 1'b0;
        err_o = !op_is_legal(op_i);
        unique case (op_i)
            OP_OR_AB:      bit_o = any_a | any_b;
            OP_AND_AC:     bit_o = any_a & any_c;
            OP_NOT_B:      bit_o = ~any_b;
            OP_NOTB_OR_C:  bit_o = ~any_b | any_c;
            OP_A_ANDNOT_C: bit_o = any_a & ~any_c;
            default:       bit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/log_op_scheduler.sv
// Round-robin scheduler sharing one logical-operator evaluator between N_REQ requesters.
// A granted job is captured, evaluated in EXEC and held on a valid/ready result port.
module log_op_scheduler
    import log_op_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*W-1:0] req_c,
    input  logic [N_REQ*3-1:0] req_op,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_bit,
    output logic [1:0]         res_id,
    output logic               res_err,
    output logic               busy,
    output logic [15:0]        done_cnt
);

    state_e       state_q, state_d;
    logic [1:0]   last_q, last_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] c_q, c_d;
    logic [2:0]   op_q, op_d;
    logic         res_valid_q, res_valid_d;
    logic         res_bit_q, res_bit_d;
    logic         res_err_q, res_err_d;
    logic [1:0]   res_id_q, res_id_d;
    logic         busy_q, busy_d;
    logic [15:0]  done_cnt_q, done_cnt_d;

    logic         arb_found;
    logic [1:0]   arb_idx;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [W-1:0] sel_c;
    logic [2:0]   sel_op;
    logic         eval_bit;
    logic         eval_err;

    // Rotating priority: search starts at the requester just after the last grant.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!arb_found && req_valid[i] && (i == (32'(last_q) + k) % N_REQ)) begin
                    arb_found = 1'b1;
                    arb_idx   = 2'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_c  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_idx == 2'(i)) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_c  = req_c[i*W +: W];
                sel_op = req_op[i*3 +: 3];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state_q == StIdle) && arb_found && (arb_idx == 2'(i));
        end
    end

    log_op_eval #(
        .W(W)
    ) u_eval (
        .a_i   (a_q),
        .b_i   (b_q),
        .c_i   (c_q),
        .op_i  (op_q),
        .bit_o (eval_bit),
        .err_o (eval_err)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        op_d        = op_q;
        res_valid_d = res_valid_q;
        res_bit_d   = res_bit_q;
        res_err_d   = res_err_q;
        res_id_d    = res_id_q;
        done_cnt_d  = done_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    c_d     = sel_c;
                    op_d    = sel_op;
                    gnt_d   = arb_idx;
                    last_d  = arb_idx;
                    state_d = StExec;
                end
            end
            StExec: begin
                res_bit_d   = eval_bit;
                res_err_d   = eval_err;
                res_id_d    = gnt_q;
                res_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 16'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= 2'(N_REQ - 1);
            gnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            op_q        <= '0;
            res_valid_q <= 1'b0;
            res_bit_q   <= 1'b0;
            res_err_q   <= 1'b0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            op_q        <= op_d;
            res_valid_q <= res_valid_d;
            res_bit_q   <= res_bit_d;
            res_err_q   <= res_err_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_bit   = res_bit_q;
    assign res_err   = res_err_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_log_op_scheduler.sv
// Bench for log_op_scheduler: directed vector table, hand-written corner sequences and a
// randomized run scored against a transaction-level model of arbitration and results.
module tb_log_op_scheduler;

    localparam int unsigned N_REQ = 3;
    localparam int unsigned W     = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ*W-1:0] req_c;
    logic [N_REQ*3-1:0] req_op;
    logic               res_valid;
    logic               res_ready;
    logic               res_bit;
    logic [1:0]         res_id;
    logic               res_err;
    logic               busy;
    logic [15:0]        done_cnt;

    log_op_scheduler #(
        .N_REQ(N_REQ),
        .W    (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_c    (req_c),
        .req_op   (req_op),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_bit  (res_bit),
        .res_id   (res_id),
        .res_err  (res_err),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    logic [W-1:0] da [N_REQ];
    logic [W-1:0] db [N_REQ];
    logic [W-1:0] dc [N_REQ];
    logic [2:0]   dop[N_REQ];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         exp_bit;
        logic         exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result {err, bit} straight from the op-code table.
    function automatic logic [1:0] ref_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [2:0] op);
        bit aa = (a != 0);
        bit bb = (b != 0);
        bit cc = (c != 0);
        case (op)
            3'd0:    return {1'b0, aa || bb};
            3'd1:    return {1'b0, aa && cc};
            3'd2:    return {1'b0, !bb};
            3'd3:    return {1'b0, !bb || cc};
            3'd4:    return {1'b0, aa && !cc};
            default: return 2'b10;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*W +: W]  = da[i];
            req_b[i*W +: W]  = db[i];
            req_c[i*W +: W]  = dc[i];
            req_op[i*3 +: 3] = dop[i];
        end
    endtask

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [2:0] op);
        da[r] = a; db[r] = b; dc[r] = c; dop[r] = op;
        drive_bus();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, '0, '0, '0, '0);
        tick();
        tick();
        rst      = 1'b0;
        exp_done = 0;
    endtask

    task automatic run_job(input string name, input int r, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] c, input logic [2:0] op,
                           input logic exp_bit, input logic exp_err);
        bit ok;
        int lat;
        set_req(r, a, b, c, op);
        req_valid[r] = 1'b1;
        res_ready    = 1'b1;
        ok = 0;
        for (int t = 0; t < 8; t++) begin
            #1;
            if (req_ready[r]) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) check({name, "_ready_timeout"}, 0, 1);
        tick();
        req_valid[r] = 1'b0;
        ok  = 0;
        lat = 0;
        for (int t = 0; t < 8; t++) begin
            if (res_valid) begin
                ok = 1;
                break;
            end
            lat++;
            tick();
        end
        if (!ok) check({name, "_res_timeout"}, 0, 1);
        check({name, "_latency"}, lat, 1);
        check({name, "_bit"}, res_bit, exp_bit);
        check({name, "_err"}, res_err, exp_err);
        check({name, "_id"}, res_id, r);
        tick();
        exp_done++;
        check({name, "_done_cnt"}, done_cnt, exp_done);
    endtask

    task automatic random_test(input int n_cycles);
        int             last_m;
        bit             outstanding;
        int             since;
        logic [15:0]    m_done;
        logic           eb;
        logic           ee;
        logic [1:0]     eid;
        logic [N_REQ-1:0] acc_mask;
        logic [N_REQ-1:0] exp_ready;
        int             g;
        do_reset();
        last_m = N_REQ - 1;
        outstanding = 0;
        since = 0;
        m_done = '0;
        acc_mask = '0;
        eb = 0; ee = 0; eid = '0;
        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            check("rnd_busy", busy, outstanding);
            check("rnd_done_cnt", done_cnt, m_done);
            if (outstanding && since >= 2) begin
                check("rnd_res_valid", res_valid, 1);
                check("rnd_res_bit", res_bit, eb);
                check("rnd_res_err", res_err, ee);
                check("rnd_res_id", res_id, eid);
            end else begin
                check("rnd_res_valid", res_valid, 0);
            end
            for (int r = 0; r < N_REQ; r++) begin
                if (acc_mask[r]) req_valid[r] = 1'b0;
                if (!req_valid[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[r] = 1'b1;
                        da[r] = ($urandom_range(0, 1) != 0) ? W'($urandom) : '0;
                        db[r] = ($urandom_range(0, 1) != 0) ? W'($urandom) : '0;
                        dc[r] = ($urandom_range(0, 1) != 0) ? W'($urandom) : '0;
                        dop[r] = 3'($urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    da[r] = W'($urandom);
                    db[r] = W'($urandom);
                    dc[r] = W'($urandom);
                    dop[r] = 3'($urandom);
                end
            end
            acc_mask = '0;
            drive_bus();
            res_ready = ($urandom_range(0, 1) != 0);
            #1;
            exp_ready = '0;
            g = -1;
            if (!outstanding) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    int idx = (last_m + k) % N_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("rnd_req_ready", req_ready, exp_ready);
            if (outstanding && since >= 2 && res_ready) begin
                outstanding = 0;
                m_done++;
            end else if (outstanding) begin
                since++;
            end
            if (g >= 0) begin
                {ee, eb} = ref_eval(da[g], db[g], dc[g], dop[g]);
                eid = 2'(g);
                last_m = g;
                outstanding = 1;
                since = 1;
                acc_mask[g] = 1'b1;
            end
            tick();
        end
        req_valid = '0;
        res_ready = 1'b0;
    endtask

    initial begin
        int n_grant;
        int n_res;

        vecs[0]  = '{3'd2, 4'h3, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[1]  = '{3'd6, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1};
        vecs[2]  = '{3'd4, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[3]  = '{3'd4, 4'h8, 4'h0, 4'h1, 1'b0, 1'b0};
        vecs[4]  = '{3'd3, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0};
        vecs[5]  = '{3'd1, 4'h1, 4'h0, 4'h4, 1'b1, 1'b0};
        vecs[6]  = '{3'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[7]  = '{3'd0, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0};
        vecs[8]  = '{3'd2, 4'h0, 4'h8, 4'h0, 1'b0, 1'b0};
        vecs[9]  = '{3'd5, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[10] = '{3'd7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[11] = '{3'd1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[12] = '{3'd3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};

        do_reset();
        tick();
        check("reset_res_valid", res_valid, 0);
        check("reset_res_bit", res_bit, 0);
        check("reset_res_id", res_id, 0);
        check("reset_res_err", res_err, 0);
        check("reset_busy", busy, 0);
        check("reset_done_cnt", done_cnt, 0);
        #1;
        check("reset_req_ready", req_ready, 0);

        // Single job, step by step.
        tick();
        set_req(0, 4'h3, 4'h0, 4'h0, 3'd2);
        req_valid = 3'b001;
        res_ready = 1'b1;
        #1;
        check("single_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("single_exec_valid", res_valid, 0);
        check("single_exec_busy", busy, 1);
        #1;
        check("single_exec_ready", req_ready, 0);
        tick();
        check("single_hold_valid", res_valid, 1);
        check("single_bit", res_bit, 1);
        check("single_id", res_id, 0);
        check("single_err", res_err, 0);
        tick();
        check("single_done_cnt", done_cnt, 1);
        check("single_idle_busy", busy, 0);
        exp_done = 1;

        for (int i = 0; i < 13; i++) begin
            run_job($sformatf("vec%0d", i), i % N_REQ, vecs[i].a, vecs[i].b, vecs[i].c,
                    vecs[i].op, vecs[i].exp_bit, vecs[i].exp_err);
        end

        // Round robin with everyone requesting continuously.
        do_reset();
        for (int r = 0; r < N_REQ; r++) set_req(r, 4'h1, 4'h0, 4'h0, 3'd0);
        req_valid = '1;
        res_ready = 1'b1;
        n_grant = 0;
        n_res = 0;
        for (int cyc = 0; cyc < 40 && n_res < 6; cyc++) begin
            if (res_valid) begin
                check("rr_res_id", res_id, n_res % N_REQ);
                check("rr_res_bit", res_bit, 1);
                n_res++;
            end
            #1;
            if (req_ready != 0 && n_grant < 6) begin
                check("rr_grant", req_ready, 1 << (n_grant % N_REQ));
                n_grant++;
            end
            tick();
        end
        check("rr_grant_count", n_grant, 6);
        check("rr_result_count", n_res, 6);
        req_valid = '0;

        // Backpressure in HOLD.
        do_reset();
        for (int r = 0; r < N_REQ; r++) set_req(r, 4'h1, 4'h0, 4'h0, 3'd0);
        req_valid = 3'b010;
        res_ready = 1'b0;
        #1;
        check("bp_accept", req_ready, 3'b010);
        tick();
        req_valid = '1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", res_valid, 1);
            check("bp_res_bit", res_bit, 1);
            check("bp_res_id", res_id, 1);
            check("bp_res_err", res_err, 0);
            check("bp_busy", busy, 1);
            #1;
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        check("bp_last_valid", res_valid, 1);
        res_ready = 1'b1;
        tick();
        check("bp_release_valid", res_valid, 0);
        check("bp_release_busy", busy, 0);
        check("bp_release_done", done_cnt, 1);
        #1;
        check("bp_next_grant", req_ready, 3'b100);
        tick();
        req_valid = '0;

        // Reset during EXEC, then during HOLD.
        do_reset();
        run_job("pre", 0, 4'h1, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
        for (int r = 0; r < N_REQ; r++) set_req(r, 4'h1, 4'h0, 4'h0, 3'd0);
        req_valid = '1;
        res_ready = 1'b0;
        #1;
        check("rstx_grant", req_ready, 3'b010);
        tick();
        check("rstx_in_exec", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstx_res_valid", res_valid, 0);
        check("rstx_done_cnt", done_cnt, 0);
        check("rstx_busy", busy, 0);
        #1;
        check("rstx_regrant", req_ready, 3'b001);
        req_valid = 3'b001;
        res_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        tick();
        check("rsth_pre_done", done_cnt, 1);
        req_valid = '1;
        res_ready = 1'b0;
        #1;
        check("rsth_grant", req_ready, 3'b010);
        tick();
        tick();
        check("rsth_hold_valid", res_valid, 1);
        check("rsth_hold_id", res_id, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsth_res_valid", res_valid, 0);
        check("rsth_done_cnt", done_cnt, 0);
        check("rsth_res_id", res_id, 0);
        check("rsth_busy", busy, 0);
        #1;
        check("rsth_regrant", req_ready, 3'b001);
        tick();
        req_valid = '0;

        random_test(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
